// File: rtl/movz_cond_write_ctrl.sv
// Conditional-move (MOVZ/MOVN) write control for the EX->MEM->WB pipeline.
// Resolves the move condition in EX, gates the result mux and tracks the write through WB.
module movz_cond_write_ctrl #(
   parameter int CNT_W  = 16,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              d_valid,
   input  logic              d_regwrite,
   input  logic              d_is_movz,
   input  logic              d_is_movn,
   input  logic [REG_AW-1:0] d_rd,
   input  logic              e_stall,
   input  logic              e_flush,
   input  logic [31:0]       e_rt_val,
   output logic              e_mux_sel,
   output logic              e_wr_valid,
   output logic [REG_AW-1:0] e_rd,
   output logic              m_wr_valid,
   output logic [REG_AW-1:0] m_rd,
   output logic              w_regwrite,
   output logic [REG_AW-1:0] w_rd,
   output logic [CNT_W-1:0]  taken_cnt,
   output logic [CNT_W-1:0]  skip_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic              e_valid_reg;
   logic              e_regwrite_reg;
   logic              e_is_movz_reg;
   logic              e_is_movn_reg;
   logic [REG_AW-1:0] e_rd_reg;

   logic              m_valid_reg;
   logic              m_we_reg;
   logic [REG_AW-1:0] m_rd_reg;

   logic              w_valid_reg;
   logic              w_we_reg;
   logic [REG_AW-1:0] w_rd_reg;

   logic              e_cond;
   logic              e_cond_op;
   logic              e_we;
   logic              e_leave;
   logic [1:0]        cnt_inc;

   // MOVZ wins when both op flags are set; plain instructions always pass
   always_comb begin
      e_cond = 1'b1;
      if (e_is_movz_reg)
         e_cond = (e_rt_val == 32'd0);
      else if (e_is_movn_reg)
         e_cond = (e_rt_val != 32'd0);
   end

   assign e_cond_op = e_is_movz_reg | e_is_movn_reg;
   assign e_we      = e_valid_reg & e_regwrite_reg & e_cond;
   assign e_leave   = e_valid_reg & ~e_stall;

   assign cnt_inc[0] = e_leave & e_cond_op &  e_cond;
   assign cnt_inc[1] = e_leave & e_cond_op & ~e_cond;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         e_valid_reg    <= 1'b0;
         e_regwrite_reg <= 1'b0;
         e_is_movz_reg  <= 1'b0;
         e_is_movn_reg  <= 1'b0;
         e_rd_reg       <= '0;
      end else if (e_flush) begin
         e_valid_reg    <= 1'b0;
         e_regwrite_reg <= 1'b0;
         e_is_movz_reg  <= 1'b0;
         e_is_movn_reg  <= 1'b0;
         e_rd_reg       <= '0;
      end else if (!e_stall) begin
         e_valid_reg    <= d_valid;
         e_regwrite_reg <= d_regwrite;
         e_is_movz_reg  <= d_is_movz;
         e_is_movn_reg  <= d_is_movn;
         e_rd_reg       <= d_rd;
      end
   end

   // The condition is frozen into m_we_reg here; later rt changes cannot reach M
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_valid_reg <= 1'b0;
         m_we_reg    <= 1'b0;
         m_rd_reg    <= '0;
      end else if (e_stall) begin
         m_valid_reg <= 1'b0;
         m_we_reg    <= 1'b0;
         m_rd_reg    <= '0;
      end else begin
         m_valid_reg <= e_valid_reg;
         m_we_reg    <= e_we;
         m_rd_reg    <= e_rd_reg;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         w_valid_reg <= 1'b0;
         w_we_reg    <= 1'b0;
         w_rd_reg    <= '0;
      end else begin
         w_valid_reg <= m_valid_reg;
         w_we_reg    <= m_we_reg;
         w_rd_reg    <= m_rd_reg;
      end
   end

   // Index 0 counts taken moves, index 1 counts skipped moves; both stick at all-ones
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         logic [CNT_W-1:0] cnt_reg;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
               cnt_reg <= '0;
            else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}}))
               cnt_reg <= cnt_reg + CNT_ONE;
         end
      end
   endgenerate

   assign taken_cnt = g_cnt[0].cnt_reg;
   assign skip_cnt  = g_cnt[1].cnt_reg;

   assign e_mux_sel  = e_valid_reg & e_cond;
   assign e_wr_valid = e_we & (e_rd_reg != '0);
   assign e_rd       = e_rd_reg;

   assign m_wr_valid = m_valid_reg & m_we_reg & (m_rd_reg != '0);
   assign m_rd       = m_rd_reg;

   assign w_regwrite = w_valid_reg & w_we_reg & (w_rd_reg != '0);
   assign w_rd       = w_rd_reg;

endmodule

// File: tb/tb_movz_cond_write_ctrl.sv
// Randomised + directed bench for movz_cond_write_ctrl with a write scoreboard.
// Expected writes are queued with their due cycle; a monitor pops them off w_regwrite.
module tb_movz_cond_write_ctrl;

   localparam int CNT_W  = 4;
   localparam int REG_AW = 5;
   localparam int SAT    = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              d_valid, d_regwrite, d_is_movz, d_is_movn;
   logic [REG_AW-1:0] d_rd;
   logic              e_stall, e_flush;
   logic [31:0]       e_rt_val;
   logic              e_mux_sel, e_wr_valid, m_wr_valid, w_regwrite;
   logic [REG_AW-1:0] e_rd, m_rd, w_rd;
   logic [CNT_W-1:0]  taken_cnt, skip_cnt;

   movz_cond_write_ctrl #(.CNT_W(CNT_W), .REG_AW(REG_AW)) dut (
      .clk(clk), .reset_n(reset_n),
      .d_valid(d_valid), .d_regwrite(d_regwrite), .d_is_movz(d_is_movz),
      .d_is_movn(d_is_movn), .d_rd(d_rd),
      .e_stall(e_stall), .e_flush(e_flush), .e_rt_val(e_rt_val),
      .e_mux_sel(e_mux_sel), .e_wr_valid(e_wr_valid), .e_rd(e_rd),
      .m_wr_valid(m_wr_valid), .m_rd(m_rd),
      .w_regwrite(w_regwrite), .w_rd(w_rd),
      .taken_cnt(taken_cnt), .skip_cnt(skip_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       v;
      logic       rw;
      logic       mz;
      logic       mn;
      logic [4:0] rd;
   } ins_t;

   typedef struct packed {
      logic [4:0] rd;
      int         due;
   } wr_t;

   int    cyc = 0;
   int    n_cmp = 0;
   int    n_bad = 0;
   wr_t   exp_q[$];
   ins_t  me;            // instruction the reference believes is in E
   int    m_taken, m_skip;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic mcond(input ins_t i, input logic [31:0] rt);
      if (i.mz) return rt == 32'd0;
      if (i.mn) return rt != 32'd0;
      return 1'b1;
   endfunction

   // One clock cycle: drive D/E inputs, check E/M/counters, advance the reference
   task automatic step(input logic dv, input logic rw, input logic mz, input logic mn,
                       input logic [4:0] rd, input logic st, input logic fl,
                       input logic [31:0] rt);
      logic c, we, mexp;
      ins_t nxt;
      @(negedge clk);
      d_valid = dv; d_regwrite = rw; d_is_movz = mz; d_is_movn = mn; d_rd = rd;
      e_stall = st; e_flush = fl; e_rt_val = rt;
      #1;
      c  = mcond(me, rt);
      we = me.v && me.rw && c;
      check("e_mux_sel", e_mux_sel, int'(me.v && c));
      check("e_wr_valid", e_wr_valid, int'(we && me.rd != 0));
      if (me.v) check("e_rd", e_rd, me.rd);
      mexp = 1'b0;
      foreach (exp_q[k]) begin
         if (exp_q[k].due == cyc + 1) begin
            mexp = 1'b1;
            check("m_rd", m_rd, exp_q[k].rd);
         end
      end
      check("m_wr_valid", m_wr_valid, mexp);
      check("taken_cnt", taken_cnt, m_taken);
      check("skip_cnt", skip_cnt, m_skip);
      if (me.v && !st) begin
         if (me.mz || me.mn) begin
            if (c) m_taken = (m_taken < SAT) ? m_taken + 1 : SAT;
            else   m_skip  = (m_skip  < SAT) ? m_skip  + 1 : SAT;
         end
         if (we && me.rd != 0) exp_q.push_back('{rd: me.rd, due: cyc + 2});
      end
      if (fl)      nxt = '0;
      else if (st) nxt = me;
      else         nxt = '{v: dv, rw: rw, mz: mz, mn: mn, rd: rd};
      me = nxt;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, $urandom());
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_e_mux_sel"}, e_mux_sel, 0);
      check({tag, "_e_wr_valid"}, e_wr_valid, 0);
      check({tag, "_e_rd"}, e_rd, 0);
      check({tag, "_m_wr_valid"}, m_wr_valid, 0);
      check({tag, "_m_rd"}, m_rd, 0);
      check({tag, "_w_regwrite"}, w_regwrite, 0);
      check({tag, "_w_rd"}, w_rd, 0);
      check({tag, "_taken_cnt"}, taken_cnt, 0);
      check({tag, "_skip_cnt"}, skip_cnt, 0);
   endtask

   // Write monitor: every asserted w_regwrite must match the oldest queued write
   always @(negedge clk) begin
      #2;
      if (w_regwrite) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL w_unexpected: got write rd=%0d expected none (cycle %0d)", w_rd, cyc);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("w_rd", w_rd, e.rd);
            check("w_due_cycle", cyc, e.due);
            $display("write rd=%0d cycle=%0d", w_rd, cyc);
         end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         wr_t e;
         e = exp_q.pop_front();
         check("w_regwrite", 0, 1);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0;
      d_valid = 0; d_regwrite = 0; d_is_movz = 0; d_is_movn = 0; d_rd = '0;
      e_stall = 0; e_flush = 0; e_rt_val = '0;
      me = '0; m_taken = 0; m_skip = 0;
      @(negedge clk); @(negedge clk);
      #1;
      check_all_zero("reset");
      #2;
      reset_n = 1'b1;

      // MOVZ taken, MOVZ skipped
      step(1, 1, 1, 0, 8, 0, 0, 32'd0);
      step(0, 0, 0, 0, 0, 0, 0, 32'd0);
      idle(3);
      step(1, 1, 1, 0, 8, 0, 0, 32'd0);
      step(0, 0, 0, 0, 0, 0, 0, 32'd5);
      idle(3);
      // MOVN back to back: rt=0 suppresses, rt=0x80000000 writes
      step(1, 1, 0, 1, 9, 0, 0, 32'd0);
      step(1, 1, 0, 1, 9, 0, 0, 32'd0);
      step(0, 0, 0, 0, 0, 0, 0, 32'h8000_0000);
      idle(3);
      // MOVZ stalled three cycles in E
      step(1, 1, 1, 0, 8, 0, 0, 32'd0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0, 32'd0);
      step(0, 0, 0, 0, 0, 0, 0, 32'd0);
      idle(3);
      // flush together with stall kills the MOVZ in E
      step(1, 1, 1, 0, 10, 0, 0, 32'd0);
      step(1, 1, 1, 0, 11, 1, 1, 32'd0);
      idle(3);
      // both op flags set behaves as MOVZ
      step(1, 1, 1, 1, 12, 0, 0, 32'd0);
      step(1, 1, 1, 1, 13, 0, 0, 32'd0);
      step(0, 0, 0, 0, 0, 0, 0, 32'd7);
      idle(3);
      // rd=0 MOVZ never writes; drive taken_cnt into saturation
      for (int i = 0; i < 20; i++) step(1, 1, 1, 0, 0, 0, 0, 32'd0);
      idle(3);
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [1:0]  op;
         logic [31:0] rt;
         op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0, 1:    rt = 32'd0;
            2:       rt = 32'h8000_0000;
            default: rt = $urandom();
         endcase
         step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 8), op[0], op[1],
              5'($urandom_range(0, 31)), ($urandom_range(0, 9) < 2),
              ($urandom_range(0, 9) < 1), rt);
      end
      // writes in flight when reset hits must vanish at once
      step(1, 1, 1, 0, 3, 0, 0, 32'd0);
      step(1, 1, 0, 0, 4, 0, 0, 32'd0);
      step(1, 1, 0, 1, 5, 0, 0, 32'd0);
      @(negedge clk);
      #3;
      reset_n = 1'b0;
      d_valid = 0; e_stall = 0; e_flush = 0;
      #1;
      check_all_zero("midreset");
      exp_q.delete();
      me = '0; m_taken = 0; m_skip = 0;
      @(negedge clk);
      #3;
      reset_n = 1'b1;
      idle(4);
      for (int i = 0; i < 100; i++)
         step(($urandom_range(0, 9) < 7), 1'b1, 1'($urandom()), 1'($urandom()),
              5'($urandom_range(0, 31)), ($urandom_range(0, 9) < 2),
              ($urandom_range(0, 9) < 1), ($urandom_range(0, 1) != 0) ? 32'd0 : $urandom());
      idle(4);
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
